// File: rtl/ssvga_line_reader_pkg.sv
// Shared constants for the VGA line reader: bank geometry, pixel width and FSM encodings.
package ssvga_line_reader_pkg;

  localparam int unsigned SsvgaBanks  = 2;
  localparam int unsigned SsvgaBankAw = 7;
  localparam int unsigned RamAw       = SsvgaBankAw + 1;
  localparam int unsigned PixW        = 8;
  localparam int unsigned HwordW      = 16;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBlank = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;

  // Line RAM address: bank select on top, halfword index below.
  function automatic logic [RamAw-1:0] bank_addr(input logic bank,
                                                 input logic [SsvgaBankAw-1:0] idx);
    return {bank, idx};
  endfunction

endpackage

// File: rtl/ssvga_line_reader_pixbuf.sv
// Two-entry halfword FIFO that hands out the low byte then the high byte of its head entry.
// Flush drops all entries and any push in the same cycle.
module ssvga_line_reader_pixbuf
  import ssvga_line_reader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [HwordW-1:0] push_data_i,
  input  logic              pop_i,
  output logic              empty_o,
  output logic [1:0]        count_o,
  output logic [PixW-1:0]   byte_o
);

  logic [HwordW-1:0] mem_q [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              byte_sel_q, byte_sel_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              consume, pop_entry;
  logic [HwordW-1:0] head;

  assign head      = mem_q[rd_ptr_q];
  assign consume   = pop_i && (cnt_q != 2'd0);
  // The head entry leaves only once its high byte has gone out.
  assign pop_entry = consume && byte_sel_q;

  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;
  assign byte_o  = byte_sel_q ? head[HwordW-1:PixW] : head[PixW-1:0];

  // Next-state for pointers, occupancy and byte selector; flush wins over push/pop.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    byte_sel_d = byte_sel_q;
    cnt_d      = cnt_q;
    if (flush_i) begin
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      byte_sel_d = 1'b0;
      cnt_d      = 2'd0;
    end else begin
      if (push_i)    wr_ptr_d   = ~wr_ptr_q;
      if (consume)   byte_sel_d = ~byte_sel_q;
      if (pop_entry) rd_ptr_d   = ~rd_ptr_q;
      cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_entry};
    end
  end

  // State and storage registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      byte_sel_q <= 1'b0;
      cnt_q      <= 2'd0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      byte_sel_q <= byte_sel_d;
      cnt_q      <= cnt_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ssvga_line_reader.sv
// VGA line reader: drains one ping-pong bank of the line RAM per active line, unpacks
// halfwords into 8bpp pixels and releases each bank back to the fetcher when done.
// Optional feature: define SSVGA_LINE_UNDERRUN_CNT_EN to add the saturating underrun_cnt_o.
module ssvga_line_reader
  import ssvga_line_reader_pkg::*;
#(
  parameter int unsigned Hwords = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  line_start_i,
  input  logic                  pix_en_i,
  output logic [PixW-1:0]       pix_data_o,
  output logic                  pix_valid_o,
  output logic                  underrun_o,
  input  logic [SsvgaBanks-1:0] bank_rdy_i,
  output logic [SsvgaBanks-1:0] bank_rel_o,
  output logic [RamAw-1:0]      ram_addr_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [HwordW-1:0]     ram_di_o,
  input  logic [HwordW-1:0]     ram_do_i
`ifdef SSVGA_LINE_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt_o
`endif
);

  localparam int unsigned IdxW    = SsvgaBankAw + 1;
  localparam int unsigned PixCntW = SsvgaBankAw + 2;
  localparam logic [IdxW-1:0]    IdxEnd  = IdxW'(Hwords);
  localparam logic [PixCntW-1:0] LastPix = PixCntW'(2 * Hwords - 1);

  logic [1:0]             state_q, state_d;
  logic                   cur_bank_q, cur_bank_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [PixCntW-1:0]     pix_cnt_q, pix_cnt_d;
  logic                   rd_vld_q;

  logic                   consume, release_bank, issue, underrun;
  logic [SsvgaBankAw-1:0] rd_idx;
  logic                   buf_empty;
  logic [1:0]             buf_cnt;
  logic [PixW-1:0]        buf_byte;

  // Line control: consume/underrun, bank release, read issue and line_start evaluation.
  always_comb begin
    state_d      = state_q;
    cur_bank_d   = cur_bank_q;
    idx_d        = idx_q;
    pix_cnt_d    = pix_cnt_q;
    consume      = 1'b0;
    release_bank = 1'b0;
    issue        = 1'b0;
    underrun     = 1'b0;
    // A new line always fetches from halfword 0 in its own start cycle.
    rd_idx       = line_start_i ? '0 : idx_q[SsvgaBankAw-1:0];

    if (state_q == StRun) begin
      if (pix_en_i) begin
        if (buf_empty) begin
          underrun = 1'b1;
        end else begin
          consume   = 1'b1;
          pix_cnt_d = pix_cnt_q + PixCntW'(1);
        end
      end
      // Completed or aborted line: exactly one release and toggle.
      if (line_start_i || (consume && (pix_cnt_q == LastPix))) begin
        release_bank = 1'b1;
        cur_bank_d   = ~cur_bank_q;
        state_d      = StIdle;
      end else if ((idx_q < IdxEnd) && (({1'b0, buf_cnt} + {2'b00, rd_vld_q}) < 3'd2)) begin
        issue = 1'b1;
      end
    end

    if (line_start_i) begin
      pix_cnt_d = '0;
      if (bank_rdy_i[cur_bank_d]) begin
        state_d = StRun;
        issue   = 1'b1;
      end else begin
        state_d  = StBlank;
        underrun = 1'b1;
      end
    end

    if (issue) begin
      idx_d = {1'b0, rd_idx} + IdxW'(1);
    end else if (line_start_i) begin
      idx_d = '0;
    end
  end

  // Bank release pulse on the bank that was being drained.
  always_comb begin
    bank_rel_o             = '0;
    bank_rel_o[cur_bank_q] = release_bank;
  end

  assign pix_valid_o = consume;
  assign pix_data_o  = consume ? buf_byte : '0;
  assign underrun_o  = underrun;
  assign ram_en_o    = issue;
  assign ram_addr_o  = bank_addr(cur_bank_d, rd_idx);
  assign ram_we_o    = 1'b0;
  assign ram_di_o    = '0;

  // Control registers; rd_vld_q marks that ram_do_i carries data this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cur_bank_q <= 1'b0;
      idx_q      <= '0;
      pix_cnt_q  <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_bank_q <= cur_bank_d;
      idx_q      <= idx_d;
      pix_cnt_q  <= pix_cnt_d;
      rd_vld_q   <= issue;
    end
  end

  // In-flight data belonging to an aborted line is dropped by suppressing its push.
  ssvga_line_reader_pixbuf u_pixbuf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (line_start_i),
    .push_i      (rd_vld_q && !line_start_i),
    .push_data_i (ram_do_i),
    .pop_i       (consume),
    .empty_o     (buf_empty),
    .count_o     (buf_cnt),
    .byte_o      (buf_byte)
  );

`ifdef SSVGA_LINE_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating count of underrun pulses; only reset clears it.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) ucnt_q <= '0;
    else       ucnt_q <= ucnt_d;
  end

  assign underrun_cnt_o = ucnt_q;
`endif

endmodule

// File: tb/tb_ssvga_line_reader.sv
// Self-checking bench for ssvga_line_reader with a behavioural line RAM and a
// pixel-count / line-age reference model.
module tb_ssvga_line_reader;

  localparam int HW = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic        pix_en = 1'b0;
  logic [7:0]  pix_data;
  logic        pix_valid, underrun;
  logic [1:0]  bank_rdy = 2'b00;
  logic [1:0]  bank_rel;
  logic [7:0]  ram_addr;
  logic        ram_en, ram_we;
  logic [15:0] ram_di;
  logic [15:0] ram_do = '0;
`ifdef SSVGA_LINE_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  logic [15:0] ram_img [256];

  int checks = 0;
  int errors = 0;

  // Reference model: is a line being drained, which bank, cycles since line_start,
  // pixels consumed so far, and the number of underruns.
  bit m_run, n_run, m_bank, n_bank;
  int m_age, n_age, m_npix, n_npix, m_ucnt, n_ucnt;
  logic [11:0] exp_vec, obs_vec;

  ssvga_line_reader #(.Hwords(HW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .line_start_i (line_start),
    .pix_en_i     (pix_en),
    .pix_data_o   (pix_data),
    .pix_valid_o  (pix_valid),
    .underrun_o   (underrun),
    .bank_rdy_i   (bank_rdy),
    .bank_rel_o   (bank_rel),
    .ram_addr_o   (ram_addr),
    .ram_en_o     (ram_en),
    .ram_we_o     (ram_we),
    .ram_di_o     (ram_di),
    .ram_do_i     (ram_do)
`ifdef SSVGA_LINE_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Line RAM port B: one-cycle read latency.
  always @(posedge clk) if (ram_en) ram_do <= ram_img[ram_addr];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // A pixel is available from the second cycle after line_start until 2*HW are consumed.
  task automatic predict();
    logic [15:0] hw;
    logic [7:0]  data;
    logic [1:0]  rel;
    bit          cons, under, valid;
    cons = 0; under = 0; valid = 0; data = '0; rel = '0;
    n_run = m_run; n_bank = m_bank; n_npix = m_npix;
    n_age = (m_age < 1000) ? m_age + 1 : m_age;
    if (m_run && pix_en) begin
      if (m_age >= 2) begin
        hw     = ram_img[8'(m_bank * HW + m_npix / 2)];
        data   = (m_npix % 2 == 1) ? hw[15:8] : hw[7:0];
        valid  = 1; cons = 1;
        n_npix = m_npix + 1;
      end else begin
        under = 1;
      end
    end
    if (m_run && (line_start || (cons && n_npix == 2 * HW))) begin
      rel[m_bank] = 1'b1;
      n_bank = ~m_bank;
      n_run  = 0;
    end
    if (line_start) begin
      if (bank_rdy[n_bank]) begin
        n_run = 1; n_age = 1; n_npix = 0;
      end else begin
        n_run = 0; under = 1;
      end
    end
    n_ucnt  = (under && m_ucnt < 65535) ? m_ucnt + 1 : m_ucnt;
    exp_vec = {valid, data, under, rel};
  endtask

  // Applies the previous cycle's model update, drives one cycle, samples, predicts.
  task automatic cyc(input bit ls, input bit pe);
    m_run = n_run; m_bank = n_bank; m_age = n_age; m_npix = n_npix; m_ucnt = n_ucnt;
    @(negedge clk);
    line_start = ls;
    pix_en     = pe;
    #1;
    obs_vec = {pix_valid, pix_data, underrun, bank_rel};
    predict();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; line_start = 1'b0; pix_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_run = 0; m_bank = 0; m_age = 0; m_npix = 0; m_ucnt = 0;
    n_run = 0; n_bank = 0; n_age = 0; n_npix = 0; n_ucnt = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pix_data, pix_valid, underrun, bank_rel, ram_addr, ram_en, ram_we, ram_di} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got data=%h v=%b u=%b rel=%b addr=%h en=%b we=%b di=%h want all 0",
               pix_data, pix_valid, underrun, bank_rel, ram_addr, ram_en, ram_we, ram_di);
    end
  endtask

  task automatic test_line_basic();
    for (int i = 0; i < HW; i++) ram_img[i] = {8'(2 * i + 2), 8'(2 * i + 1)};
    for (int i = HW; i < 256; i++) ram_img[i] = 16'($urandom);
    bank_rdy = 2'b01;
    cyc(1, 0);
    cyc(0, 0);
    for (int k = 0; k < 2 * HW; k++) begin
      cyc(0, 1);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL line_basic k=%0d: got %h want %h", k, obs_vec, exp_vec);
      end
      if (k < 4) begin
        checks++;
        if (pix_data !== 8'(k + 1) || pix_valid !== 1'b1) begin
          errors++;
          $display("FAIL line_basic pattern k=%0d: got %h/%b want %h/1", k, pix_data, pix_valid,
                   8'(k + 1));
        end
      end
    end
    checks++;
    if (bank_rel !== 2'b01) begin
      errors++;
      $display("FAIL line_basic release: got %b want 01", bank_rel);
    end
  endtask

  task automatic test_next_line();
    bit seen = 0;
    bank_rdy = 2'b10;
    for (int c = 0; c < 2000; c++) begin
      cyc(c == 0, (c < 2) ? 1'b0 : 1'($urandom_range(0, 1)));
      if (c < 3 && ram_en === 1'b1 && ram_addr === 8'h80) seen = 1;
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL next_line c=%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      if (!n_run) break;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL next_line addr: no read of 80 seen, want read of 80");
    end
  endtask

  task automatic test_no_bank();
    int unders = 0;
    int rels = 0;
    bank_rdy = 2'b00;
    for (int c = 0; c < 21; c++) begin
      cyc(c == 0, (c == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL no_bank c=%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      unders += int'(underrun);
      rels   += int'(bank_rel != 2'b00) + int'(pix_valid);
    end
    checks++;
    if (unders != 1 || rels != 0) begin
      errors++;
      $display("FAIL no_bank pulses: got underruns=%0d rel/valid=%0d want 1 and 0", unders, rels);
    end
  endtask

  task automatic test_abort();
    do_reset();
    bank_rdy = 2'b11;
    cyc(1, 0);
    cyc(0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL abort k=%0d: got %h want %h", k, obs_vec, exp_vec);
      end
    end
    cyc(1, 0);
    checks++;
    if (bank_rel !== 2'b01 || obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL abort release: got rel=%b vec=%h want rel=01 vec=%h", bank_rel, obs_vec, exp_vec);
    end
    cyc(0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL abort newline k=%0d: got %h want %h", k, obs_vec, exp_vec);
      end
      if (k == 0) begin
        checks++;
        if (pix_data !== ram_img[8'h80][7:0] || pix_valid !== 1'b1) begin
          errors++;
          $display("FAIL abort bank1 pixel: got %h/%b want %h/1", pix_data, pix_valid,
                   ram_img[8'h80][7:0]);
        end
      end
    end
  endtask

  task automatic test_early_pix();
    do_reset();
    bank_rdy = 2'b01;
    cyc(1, 0);
    cyc(0, 1);
    checks++;
    if (underrun !== 1'b1 || pix_valid !== 1'b0 || pix_data !== 8'h00) begin
      errors++;
      $display("FAIL early_pix cycle1: got u=%b v=%b d=%h want u=1 v=0 d=00", underrun, pix_valid,
               pix_data);
    end
    cyc(0, 1);
    checks++;
    if (pix_data !== 8'h01 || pix_valid !== 1'b1 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL early_pix cycle2: got d=%h v=%b u=%b want d=01 v=1 u=0", pix_data, pix_valid,
               underrun);
    end
  endtask

  task automatic test_final_and_start();
    do_reset();
    bank_rdy = 2'b11;
    cyc(1, 0);
    cyc(0, 0);
    for (int k = 0; k < 2 * HW - 1; k++) cyc(0, 1);
    cyc(1, 1);
    checks++;
    if (bank_rel !== 2'b01 || obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL final_and_start: got rel=%b vec=%h want rel=01 vec=%h", bank_rel, obs_vec,
               exp_vec);
    end
    cyc(0, 0);
    cyc(0, 1);
    checks++;
    if (pix_data !== ram_img[8'h80][7:0] || pix_valid !== 1'b1 || bank_rel !== 2'b00) begin
      errors++;
      $display("FAIL final_and_start next: got %h/%b rel=%b want %h/1 rel=00", pix_data, pix_valid,
               bank_rel, ram_img[8'h80][7:0]);
    end
  endtask

  task automatic test_reset_mid_line();
    bank_rdy = 2'b11;
    for (int k = 0; k < 30; k++) cyc(0, 1);
    do_reset();
    checks++;
    if ({pix_data, pix_valid, underrun, bank_rel, ram_en} !== '0) begin
      errors++;
      $display("FAIL reset_mid_line outputs: got d=%h v=%b u=%b rel=%b en=%b want all 0",
               pix_data, pix_valid, underrun, bank_rel, ram_en);
    end
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 1);
    checks++;
    if (pix_data !== ram_img[0][7:0] || pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_line bank0: got %h/%b want %h/1", pix_data, pix_valid,
               ram_img[0][7:0]);
    end
  endtask

  task automatic test_random();
    int abort_at, thr;
    do_reset();
    for (int i = 0; i < 256; i++) ram_img[i] = 16'($urandom);
    for (int line = 0; line < 14; line++) begin
      bank_rdy = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      abort_at = $urandom_range(3, 900);
      thr      = $urandom_range(1, 4);
      cyc(1, 1'($urandom_range(0, 1)));
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random line=%0d start: got %h want %h", line, obs_vec, exp_vec);
      end
      for (int c = 0; c < 900; c++) begin
        if (c == abort_at || (!n_run && c > 4)) break;
        cyc(0, $urandom_range(0, 3) < thr);
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++;
          $display("FAIL random line=%0d c=%0d: got %h want %h", line, c, obs_vec, exp_vec);
        end
      end
    end
  endtask

`ifdef SSVGA_LINE_UNDERRUN_CNT_EN
  task automatic test_underrun_cnt();
    do_reset();
    bank_rdy = 2'b00;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0);
      cyc(0, 1);
    end
    cyc(0, 0);
    checks++;
    if (underrun_cnt !== 16'd3 || int'(underrun_cnt) != m_ucnt) begin
      errors++;
      $display("FAIL underrun_cnt: got %0d want 3 (model %0d)", underrun_cnt, m_ucnt);
    end
    do_reset();
    checks++;
    if (underrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL underrun_cnt reset: got %0d want 0", underrun_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line_basic();
    test_next_line();
    test_no_bank();
    test_abort();
    test_early_pix();
    test_final_and_start();
    test_reset_mid_line();
    test_random();
`ifdef SSVGA_LINE_UNDERRUN_CNT_EN
    test_underrun_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
